// File: rtl/d_sram_bridge_pkg.sv
// Shared definitions for the data-side sram-like bus bridge: FSM state
// encoding and bus transfer-size codes.
package d_sram_bridge_pkg;

  // Bridge FSM states. The encoding is fixed so that state values can be
  // compared across debug tooling.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bridgeState_t;

  // sram-like bus transfer sizes.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/d_wen_size_enc.sv
// Maps the M-stage byte write enables and address onto the bus request
// fields: write flag, transfer size and the address placed on the bus.
module d_wen_size_enc
  import d_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        data_size,
  output logic              data_wr,
  output logic [ADDR_W-1:0] data_addr
);

  // Stores keep their byte address and get a size from the enable pattern;
  // loads always fetch the aligned word and leave extraction downstream.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    data_wr   = |mem_wen;
    data_size = SZ_W;
    data_addr = {mem_addr[ADDR_W-1:2], 2'b00};
    if (data_wr) begin
      data_addr = mem_addr;
      case (mem_wen)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: data_size = SZ_B;
        4'b0011, 4'b1100:                   data_size = SZ_H;
        default:                            data_size = SZ_W; // full word or illegal pattern
      endcase
    end
  end

endmodule

// File: rtl/d_sram_bridge.sv
// Data-side bridge from the M-stage memory port to the sram-like bus.
// Each M-stage load/store becomes exactly one bus transaction; d_stall is held
// while it is outstanding and the load word is kept until the pipeline stall
// releases. Optional performance counters: define D_SRAM_BRIDGE_PERF_EN.
module d_sram_bridge
  import d_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              longest_stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              d_stall,
`ifdef D_SRAM_BRIDGE_PERF_EN
  output logic [CNT_W-1:0]  perf_stall_cyc,
  output logic [CNT_W-1:0]  perf_txn_cnt,
`endif
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  if (DATA_W != 32 || CNT_W < 1) begin : gBadParams
    $error("d_sram_bridge: only DATA_W=32 and CNT_W>=1 are supported");
  end

  bridgeState_t      stateQ, stateD;
  logic              reqWrQ;
  logic [1:0]        reqSizeQ;
  logic [ADDR_W-1:0] reqAddrQ;
  logic [DATA_W-1:0] reqWdataQ;
  logic [DATA_W-1:0] rdataBufQ;

  logic              encWr;
  logic [1:0]        encSize;
  logic [ADDR_W-1:0] encAddr;

  d_wen_size_enc #(.ADDR_W(ADDR_W)) uEnc (
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .data_size(encSize),
    .data_wr  (encWr),
    .data_addr(encAddr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) stateQ <= IDLE;
    else      stateQ <= stateD;
  end

  // Capture the request fields when a new access is accepted from IDLE, so
  // later cycles of the transaction ignore changes on the M-stage inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqWrQ    <= 1'b0;
      reqSizeQ  <= SZ_B;
      reqAddrQ  <= '0;
      reqWdataQ <= '0;
    end else if (stateQ == IDLE && mem_en) begin
      reqWrQ    <= encWr;
      reqSizeQ  <= encSize;
      reqAddrQ  <= encAddr;
      reqWdataQ <= mem_wdata;
    end
  end

  // Load-return buffer: written only by a load response, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this is a single word register, not a memory array, so it is
    // reset to give mem_rdata a defined value before the first load.
    if (!rst)                                              rdataBufQ <= '0;
    else if (stateQ == DATA && data_data_ok && !reqWrQ)    rdataBufQ <= data_rdata;
  end

  // Next-state and bus/stall outputs. IDLE drives the bus straight from the
  // live inputs so a request costs no extra cycle; later states use the
  // captured fields. Reset forces every output low at once.
  always_comb begin
    stateD     = stateQ;
    data_req   = 1'b0;
    d_stall    = 1'b0;
    data_wr    = 1'b0;
    data_size  = SZ_B;
    data_addr  = '0;
    data_wdata = '0;
    mem_rdata  = rdataBufQ;

    case (stateQ)
      IDLE: begin
        if (mem_en) begin
          data_req   = 1'b1;
          d_stall    = 1'b1;
          data_wr    = encWr;
          data_size  = encSize;
          data_addr  = encAddr;
          data_wdata = mem_wdata;
          stateD     = data_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        data_req   = 1'b1;
        d_stall    = 1'b1;
        data_wr    = reqWrQ;
        data_size  = reqSizeQ;
        data_addr  = reqAddrQ;
        data_wdata = reqWdataQ;
        if (data_addr_ok) stateD = DATA;
      end
      DATA: begin
        d_stall    = 1'b1;
        data_wr    = reqWrQ;
        data_size  = reqSizeQ;
        data_addr  = reqAddrQ;
        data_wdata = reqWdataQ;
        if (data_data_ok) stateD = DONE;
      end
      DONE: begin
        // Wait for the whole pipeline to move on; mem_en is still high for
        // the same instruction here and must not start a second access.
        if (!longest_stall) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase

    if (!rst) begin
      data_req   = 1'b0;
      d_stall    = 1'b0;
      data_wr    = 1'b0;
      data_size  = SZ_B;
      data_addr  = '0;
      data_wdata = '0;
    end
  end

`ifdef D_SRAM_BRIDGE_PERF_EN
  // Performance counters: stall cycles and accepted bus handshakes, wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cyc <= '0;
      perf_txn_cnt   <= '0;
    end else begin
      if (d_stall)                 perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (data_req && data_addr_ok) perf_txn_cnt  <= perf_txn_cnt + 1'b1;
    end
  end
`endif

endmodule
